pipe_field: RTL

- Obstacle side of the Flappy Bird game; the other end of the bird block's `lights`/`gameover` interface.
- Consumes the bird's 16-row light column and generates scrolling pipe columns with random gaps, advanced on the game tick `clkG`.
- Detects collisions and drives the sticky `gameover` back to the bird, plus a pass counter for the score display.

---
 rtl/flappy_pkg.sv | 14 +
 rtl/lfsr8.sv | 18 +
 rtl/pipe_field.sv | 111 +++++++++++
 3 files changed

// File: rtl/flappy_pkg.sv
// Shared definitions for the Flappy Bird pipe field: default geometry, FSM states, LFSR constants.
package flappy_pkg;

   localparam int DEF_ROWS = 16;
   localparam int DEF_COLS = 8;
   localparam int DEF_GAP  = 4;

   typedef enum logic [1:0] {IDLE, RUN, OVER} state_t;

   localparam logic [7:0] LFSR_SEED = 8'hA5;
   // x^8+x^6+x^5+x^4+1, stages 8/6/5/4 map to bits 7/5/4/3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR; steps every clk cycle, seeded on reset.
module lfsr8
   import flappy_pkg::*;
(
   input  logic       clk,
   input  logic       reset,
   output logic [7:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= LFSR_SEED;
      end else begin
         q <= {q[6:0], ^(q & LFSR_TAPS)};
      end
   end

endmodule

// File: rtl/pipe_field.sv
// Scrolling pipe columns, collision detection and pass score for the Flappy Bird game.
// Optional PIPE_SPEEDUP_EN shortens the spawn interval as the score grows.
module pipe_field
   import flappy_pkg::*;
#(
   parameter int ROWS     = DEF_ROWS,
   parameter int COLS     = DEF_COLS,
   parameter int GAP      = DEF_GAP,
   parameter int SPACING  = 4,
   parameter int BIRD_COL = 1,
   parameter int SCORE_W  = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clkG,
   input  logic                   key,
   input  logic [ROWS-1:0]        lights,
   output logic [COLS*ROWS-1:0]   pipes,
   output logic                   gameover,
   output logic [SCORE_W-1:0]     score
);

   localparam int CNT_W = 8;

   state_t             state;
   logic [7:0]         lfsr_q;
   logic [CNT_W-1:0]   spawn_cnt;
   logic [CNT_W-1:0]   interval;
   logic [ROWS-1:0]    bird_col;
   logic [ROWS-1:0]    new_col;
   logic               hit;
   logic               spawn_now;
   logic               advance;

   function automatic logic [ROWS-1:0] spawn_col(input logic [7:0] r);
      logic [7:0]      g;
      logic [ROWS-1:0] hole;
      g    = r % 8'(ROWS - GAP + 1);
      hole = {{(ROWS-GAP){1'b0}}, {GAP{1'b1}}} << g;
      return ~hole;
   endfunction

   lfsr8 u_lfsr (
      .clk   (clk),
      .reset (reset),
      .q     (lfsr_q)
   );

   assign bird_col  = pipes[BIRD_COL*ROWS +: ROWS];
   // An off-screen bird (no light) counts as a crash
   assign hit       = ((lights & bird_col) != '0) || (lights == '0);
   assign advance   = (state == RUN) && !hit && clkG;
   assign spawn_now = (spawn_cnt == interval - 1'b1);
   assign new_col   = spawn_now ? spawn_col(lfsr_q) : '0;

`ifdef PIPE_SPEEDUP_EN
   logic [CNT_W-1:0]   next_interval;
   logic [SCORE_W-1:0] shrink;

   always_comb begin
      shrink = score >> 3;
      if (int'(shrink) + 2 >= SPACING) begin
         next_interval = CNT_W'(2);
      end else begin
         next_interval = CNT_W'(SPACING - int'(shrink));
      end
   end

   // Interval only changes at a wrap so the counter never overshoots it
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         interval <= CNT_W'(SPACING);
      end else if (advance && spawn_now) begin
         interval <= next_interval;
      end
   end
`else
   assign interval = CNT_W'(SPACING);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pipes     <= '0;
         gameover  <= 1'b0;
         score     <= '0;
         spawn_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (key) state <= RUN;
            end
            RUN: begin
               if (hit) begin
                  state    <= OVER;
                  gameover <= 1'b1;
               end else if (clkG) begin
                  pipes     <= {new_col, pipes[COLS*ROWS-1:ROWS]};
                  spawn_cnt <= spawn_now ? '0 : spawn_cnt + 1'b1;
                  if (bird_col != '0 && score != '1) score <= score + 1'b1;
               end
            end
            OVER: begin
               gameover <= 1'b1;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
